snn_mac_seq: RTL and testbench
==============================

Name: snn_mac_seq

Overview:
Parametrised, time-multiplexed spike-gated multiply-accumulate for SNN layers. It is the successor of the 5-input combinational layer-2 MAC. It accepts one spike vector and its signed weight vector through a valid/ready handshake. It accumulates LANES weights per cycle at full precision, then presents a saturated or wrapped neuron input current downstream through a valid/ready handshake.

Parameters:
N_IN, 5, number of synaptic inputs (spikes) per neuron
W_WIDTH, 8, signed two's-complement weight width
OUT_WIDTH, 8, signed width of sum_out
LANES, 1, weights processed per cycle (1..N_IN)
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap (legacy behaviour)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  spikes/weights valid
in_ready  out  1  block can accept a new vector
spikes  in  N_IN  spike bit per input, bit i gates weight i
weights  in  N_IN*W_WIDTH  weight i at [i*W_WIDTH +: W_WIDTH], signed
out_valid  out  1  sum_out/sat_flag valid
out_ready  in  1  downstream accepts result
sum_out  out  OUT_WIDTH  signed neuron input sum
sat_flag  out  1  result was clamped (SATURATE=1) or wrapped (SATURATE=0)

Behaviour:
- Reset (async, rst_n low): state=IDLE, in_ready=0 while in reset, out_valid=0, sum_out=0, sat_flag=0, accumulator=0, beat counter=0. A reset mid-operation discards the current vector with no output.
- BEATS = ceil(N_IN/LANES). ACC_W = W_WIDTH + clog2(N_IN) + 1. The internal accumulator never overflows.
- State IDLE: in_ready=1. On the in_valid&&in_ready edge, register spikes and weights, clear the accumulator and beat counter, and go to ACCUM.
- State ACCUM: in_ready=0. On each edge, add the lane sum for beat b to the accumulator.
  - The lane sum for beat b is the sum over lanes j of (spikes[b*LANES+j] ? sign-extended weight : 0).
  - Lane indices at or above N_IN contribute 0 (padding).
  - Increment b. After the edge that processes beat BEATS-1, go to DONE.
- State DONE: out_valid=1.
  - sum_out = clamp(acc) to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] if SATURATE=1, else acc[OUT_WIDTH-1:0].
  - sat_flag=1 iff acc is outside that range.
  - sum_out and sat_flag are registered and held stable while out_ready=0.
  - On the out_valid&&out_ready edge, clear out_valid and go to IDLE. No new input is accepted in the same cycle.
- Latency: out_valid is high after the BEATS-th rising edge following the accepting edge. Throughput is one vector per BEATS+2 cycles with out_ready held high.
- All spikes zero gives sum_out=0 and sat_flag=0 after the normal latency. There is no early exit.
- Inputs are sampled only on the accepting edge. Changes to spikes/weights during ACCUM/DONE have no effect.
- Arithmetic is signed throughout. There is no truncation before the final output stage.

Decomposition:
- Shared package snn_pkg holds:
  - the state encoding (IDLE, ACCUM, DONE)
  - a clog2 constant function
  - localparam helpers for BEATS and ACC_W
- One combinational sub-module, snn_lane_sum (LANES spikes, LANES weights → signed ACC_W partial sum), instantiated once inside snn_mac_seq.

Test Plan:
- Basic sum (N_IN=5, LANES=1, SATURATE=1):
  - spikes=5'b11111, all weights=10 → sum_out=50, sat_flag=0.
  - out_valid rises on the 5th edge after acceptance.
  - in_ready is low from acceptance until the output handshake completes.
- Gating and sign: spikes=5'b10101, weights {w4..w0}={-3,7,20,9,-8} → -3+20-8=9.
  - Then spikes=0 → 0.
- Saturation:
  - all weights=100, spikes all 1 → sum_out=127, sat_flag=1.
  - all weights=-100 → sum_out=-128, sat_flag=1.
- Wrap (SATURATE=0): all weights=100, spikes all 1 → 500 mod 256 → sum_out=-12, sat_flag=1.
- Backpressure/reset:
  - Hold out_ready=0 for 3 cycles → out_valid and sum_out stable, in_ready=0.
  - Next vector is accepted only after the handshake.
  - Separately, pulse rst_n low in ACCUM beat 2 → all outputs 0 immediately, no out_valid afterwards, next vector processed correctly.
- LANES=2, N_IN=5 (BEATS=3, padded lane): spikes all 1, weights {1,2,3,4,5} → sum_out=15 with out_valid after the 3rd edge.

Source files
------------

// File: rtl/snn_mac_seq_pkg.sv
// Shared types and elaboration helpers for the time-multiplexed SNN MAC.
// Holds the FSM encoding and the sizing functions used by the top and the lane adder.
package snn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int beats_f(input int n_in, input int lanes);
      return (n_in + lanes - 1) / lanes;
   endfunction

   // One guard bit on top of the worst-case growth keeps the accumulator exact.
   function automatic int acc_w_f(input int w_width, input int n_in);
      return w_width + clog2(n_in) + 1;
   endfunction

endpackage

// File: rtl/snn_mac_seq_lane_sum.sv
// Combinational spike-gated adder: sums the sign-extended weights whose spike bit is set.
module snn_lane_sum #(
   parameter int LANES   = 1,
   parameter int W_WIDTH = 8,
   parameter int ACC_W   = 12
) (
   input  logic [LANES-1:0]         spk,
   input  logic [LANES*W_WIDTH-1:0] wgt,
   output logic signed [ACC_W-1:0]  psum
);

   always_comb begin
      psum = '0;
      for (int j = 0; j < LANES; j++) begin
         if (spk[j]) psum = psum + ACC_W'($signed(wgt[j*W_WIDTH +: W_WIDTH]));
      end
   end

endmodule

// File: rtl/snn_mac_seq.sv
// Sequential spike-gated MAC: accepts one spike/weight vector, accumulates LANES
// weights per cycle at full precision, then offers a clamped or wrapped sum downstream.
module snn_mac_seq
   import snn_pkg::*;
#(
   parameter int N_IN      = 5,
   parameter int W_WIDTH   = 8,
   parameter int OUT_WIDTH = 8,
   parameter int LANES     = 1,
   parameter int SATURATE  = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_IN-1:0]             spikes,
   input  logic [N_IN*W_WIDTH-1:0]     weights,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [OUT_WIDTH-1:0] sum_out,
   output logic                        sat_flag
);

   localparam int BEATS  = beats_f(N_IN, LANES);
   localparam int ACC_W  = acc_w_f(W_WIDTH, N_IN);
   localparam int BEAT_W = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);
   localparam int PAD    = BEATS * LANES;
   localparam int EXT_W  = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;

   localparam logic signed [EXT_W-1:0] SMAX = {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SMIN = ~SMAX;

   state_e                     state_q, state_d;
   logic [N_IN-1:0]            spk_q, spk_d;
   logic [N_IN*W_WIDTH-1:0]    wgt_q, wgt_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [BEAT_W-1:0]          beat_q, beat_d;
   logic signed [OUT_WIDTH-1:0] sum_q, sum_d;
   logic                       sat_q, sat_d;

   logic [PAD-1:0]             spk_pad;
   logic [PAD*W_WIDTH-1:0]     wgt_pad;
   logic [LANES-1:0]           lane_spk;
   logic [LANES*W_WIDTH-1:0]   lane_wgt;
   logic signed [ACC_W-1:0]    psum;
   logic signed [ACC_W-1:0]    acc_nxt;
   logic signed [EXT_W-1:0]    acc_ext;
   logic signed [OUT_WIDTH-1:0] res_sum;
   logic                       res_sat;

   // Lanes past N_IN in the final beat see spike=0 and therefore add nothing.
   always_comb begin
      spk_pad = '0;
      wgt_pad = '0;
      spk_pad[N_IN-1:0]         = spk_q;
      wgt_pad[N_IN*W_WIDTH-1:0] = wgt_q;
      lane_spk = spk_pad[int'(beat_q)*LANES +: LANES];
      lane_wgt = wgt_pad[int'(beat_q)*LANES*W_WIDTH +: LANES*W_WIDTH];
   end

   snn_lane_sum #(
      .LANES   (LANES),
      .W_WIDTH (W_WIDTH),
      .ACC_W   (ACC_W)
   ) u_lane_sum (
      .spk  (lane_spk),
      .wgt  (lane_wgt),
      .psum (psum)
   );

   // Output stage works on the post-add value so the result is registered on the last beat.
   always_comb begin
      acc_nxt = acc_q + psum;
      acc_ext = EXT_W'(acc_nxt);
      res_sat = (acc_ext > SMAX) || (acc_ext < SMIN);
      res_sum = acc_ext[OUT_WIDTH-1:0];
      if (SATURATE != 0) begin
         if (acc_ext > SMAX)      res_sum = SMAX[OUT_WIDTH-1:0];
         else if (acc_ext < SMIN) res_sum = SMIN[OUT_WIDTH-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      spk_d   = spk_q;
      wgt_d   = wgt_q;
      acc_d   = acc_q;
      beat_d  = beat_q;
      sum_d   = sum_q;
      sat_d   = sat_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               spk_d   = spikes;
               wgt_d   = weights;
               acc_d   = '0;
               beat_d  = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d  = acc_nxt;
            beat_d = beat_q + 1'b1;
            if (beat_q == BEAT_W'(BEATS-1)) begin
               sum_d   = res_sum;
               sat_d   = res_sat;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         spk_q   <= '0;
         wgt_q   <= '0;
         acc_q   <= '0;
         beat_q  <= '0;
         sum_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         spk_q   <= spk_d;
         wgt_q   <= wgt_d;
         acc_q   <= acc_d;
         beat_q  <= beat_d;
         sum_q   <= sum_d;
         sat_q   <= sat_d;
      end
   end

   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum_out   = sum_q;
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_snn_mac_seq.sv
// Directed bench for snn_mac_seq: three instances cover saturate, wrap and two-lane configs.
module tb_snn_mac_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              iv  [3];
   logic              ir  [3];
   logic [4:0]        sp  [3];
   logic [39:0]       wt  [3];
   logic              ov  [3];
   logic              orr [3];
   logic signed [7:0] so  [3];
   logic              sf  [3];

   int n_vec = 0;
   int n_err = 0;

   snn_mac_seq #(.N_IN(5), .W_WIDTH(8), .OUT_WIDTH(8), .LANES(1), .SATURATE(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .spikes(sp[0]),
      .weights(wt[0]), .out_valid(ov[0]), .out_ready(orr[0]), .sum_out(so[0]), .sat_flag(sf[0]));

   snn_mac_seq #(.N_IN(5), .W_WIDTH(8), .OUT_WIDTH(8), .LANES(1), .SATURATE(0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .spikes(sp[1]),
      .weights(wt[1]), .out_valid(ov[1]), .out_ready(orr[1]), .sum_out(so[1]), .sat_flag(sf[1]));

   snn_mac_seq #(.N_IN(5), .W_WIDTH(8), .OUT_WIDTH(8), .LANES(2), .SATURATE(1)) u_l2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .spikes(sp[2]),
      .weights(wt[2]), .out_valid(ov[2]), .out_ready(orr[2]), .sum_out(so[2]), .sat_flag(sf[2]));

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] pack5(input int w4, input int w3, input int w2, input int w1, input int w0);
      return {8'(w4), 8'(w3), 8'(w2), 8'(w1), 8'(w0)};
   endfunction

   // Apply one vector to instance k, optionally stall the output for hold cycles.
   task automatic run_vec(input int k, input string tag, input logic [4:0] s, input logic [39:0] w,
                          input int lat, input int es, input int esat, input int hold);
      int n;
      logic signed [7:0] held;
      @(negedge clk);
      chk({tag, ".in_ready_idle"}, int'(ir[k]), 1);
      iv[k] = 1'b1; sp[k] = s; wt[k] = w; orr[k] = (hold == 0);
      @(negedge clk);
      iv[k] = 1'b0; sp[k] = ~s; wt[k] = ~w;
      n = 0;
      while (!ov[k] && n < 20) begin
         if (ir[k]) chk({tag, ".in_ready_busy"}, int'(ir[k]), 0);
         @(negedge clk);
         n++;
      end
      chk({tag, ".latency"}, n, lat);
      chk({tag, ".sum"}, int'(so[k]), es);
      chk({tag, ".sat"}, int'(sf[k]), esat);
      held = so[k];
      for (int h = 0; h < hold; h++) begin
         iv[k] = 1'b1;
         @(negedge clk);
         chk({tag, ".hold_valid"}, int'(ov[k]), 1);
         chk({tag, ".hold_sum"}, int'(so[k]), int'(held));
         chk({tag, ".hold_in_ready"}, int'(ir[k]), 0);
      end
      iv[k] = 1'b0;
      orr[k] = 1'b1;
      @(negedge clk);
      chk({tag, ".valid_clr"}, int'(ov[k]), 0);
      chk({tag, ".in_ready_back"}, int'(ir[k]), 1);
   endtask

   initial begin
      int seen;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; sp[k] = '0; wt[k] = '0; orr[k] = 1'b1;
      end
      #12;
      for (int k = 0; k < 3; k++) begin
         chk("rst.out_valid", int'(ov[k]), 0);
         chk("rst.sum", int'(so[k]), 0);
         chk("rst.sat", int'(sf[k]), 0);
         chk("rst.in_ready", int'(ir[k]), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      run_vec(0, "sat.basic",  5'b11111, pack5(10, 10, 10, 10, 10),     5,   50, 0, 0);
      run_vec(0, "sat.gate",   5'b10101, pack5(-3, 7, 20, 9, -8),       5,    9, 0, 0);
      run_vec(0, "sat.zero",   5'b00000, pack5(55, 66, 77, 88, 99),     5,    0, 0, 0);
      run_vec(0, "sat.pos",    5'b11111, pack5(100, 100, 100, 100, 100), 5,  127, 1, 0);
      run_vec(0, "sat.neg",    5'b11111, pack5(-100, -100, -100, -100, -100), 5, -128, 1, 0);
      run_vec(0, "sat.max",    5'b11111, pack5(27, 25, 25, 25, 25),     5,  127, 0, 0);
      run_vec(0, "sat.min",    5'b11111, pack5(-28, -25, -25, -25, -25), 5, -128, 0, 0);
      run_vec(0, "sat.bp",     5'b11111, pack5(5, 4, 3, 2, 1),          5,   15, 0, 3);

      run_vec(1, "wrap.pos",   5'b11111, pack5(100, 100, 100, 100, 100), 5,  -12, 1, 0);
      run_vec(1, "wrap.neg",   5'b11111, pack5(-100, -100, -100, -100, -100), 5, 12, 1, 0);
      run_vec(1, "wrap.gate",  5'b10101, pack5(-3, 7, 20, 9, -8),       5,    9, 0, 0);

      run_vec(2, "l2.basic",   5'b11111, pack5(5, 4, 3, 2, 1),          3,   15, 0, 0);
      run_vec(2, "l2.sat",     5'b11111, pack5(100, 100, 100, 100, 100), 3,  127, 1, 0);
      run_vec(2, "l2.pad",     5'b10000, pack5(-7, 50, 50, 50, 50),     3,   -7, 0, 0);

      // Reset during ACCUM beat 2: output registers must clear and no result appears.
      run_vec(0, "pre_rst",    5'b11111, pack5(20, 20, 20, 20, 20),     5,  100, 0, 0);
      @(negedge clk);
      iv[0] = 1'b1; sp[0] = 5'b11111; wt[0] = pack5(9, 9, 9, 9, 9);
      @(negedge clk);
      iv[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst.out_valid", int'(ov[0]), 0);
      chk("midrst.sum", int'(so[0]), 0);
      chk("midrst.sat", int'(sf[0]), 0);
      chk("midrst.in_ready", int'(ir[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (ov[0]) seen = 1;
      end
      chk("midrst.no_output", seen, 0);
      run_vec(0, "post_rst",   5'b01110, pack5(1, -40, 30, -2, 77),     5,  -12, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
